// File: rtl/axis_rd_checker.sv
// axis_rd_checker: AXI-Stream sink that checks DDR read-back beats against an incrementing pattern and times the run
//   clk, rstn                       clock, synchronous active-low reset
//   s_axis_*                        stream input; tstrb/tlast ignored, tready registered
//   START/NBURST/SEED/STALL_REG     run request (level), burst count, pattern seed, tready-low cycles per beat
//   DONE/BUSY_REG                   run status
//   BEATS/CYCLES/ERR_CNT_REG        accepted beats, elapsed run cycles, mismatching beats
//   FIRST_ERR_IDX_REG               index of first mismatching beat, all ones if none
module axis_rd_checker #(
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = 7
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    START_REG,
    input  logic [31:0]             NBURST_REG,
    input  logic [31:0]             SEED_REG,
    input  logic [3:0]              STALL_REG,
    output logic                    DONE_REG,
    output logic                    BUSY_REG,
    output logic [31:0]             BEATS_REG,
    output logic [31:0]             CYCLES_REG,
    output logic [31:0]             ERR_CNT_REG,
    output logic [31:0]             FIRST_ERR_IDX_REG
);
    typedef enum logic [1:0] {IDLE, LATCH, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] total_q, total_d, seed_q, seed_d, beats_q, beats_d;
    logic [31:0] cycles_q, cycles_d, err_q, err_d, first_q, first_d;
    logic [3:0]  stall_q, stall_d, scnt_q, scnt_d;
    logic [31:0] total_new, exp_word;
    logic        accept, mismatch, unused;
    assign unused        = ^{s_axis_tstrb, s_axis_tlast};
    assign total_new     = NBURST_REG * 32'(BURST_LENGTH + 1);
    assign exp_word      = seed_q + beats_q;
    assign s_axis_tready = (state_q == RUN) && (scnt_q == 4'd0);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign mismatch      = s_axis_tdata != {(DATA_WIDTH/32){exp_word}};
    assign DONE_REG          = state_q == DONE;
    assign BUSY_REG          = state_q == RUN;
    assign BEATS_REG         = beats_q;
    assign CYCLES_REG        = cycles_q;
    assign ERR_CNT_REG       = err_q;
    assign FIRST_ERR_IDX_REG = first_q;
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        seed_d   = seed_q;
        stall_d  = stall_q;
        scnt_d   = scnt_q;
        beats_d  = beats_q;
        cycles_d = cycles_q;
        err_d    = err_q;
        first_d  = first_q;
        case (state_q)
            IDLE: state_d = START_REG ? LATCH : IDLE;
            LATCH: begin
                total_d  = total_new;
                seed_d   = SEED_REG;
                stall_d  = STALL_REG;
                scnt_d   = 4'd0;
                beats_d  = 32'd0;
                cycles_d = 32'd0;
                err_d    = 32'd0;
                first_d  = '1;
                state_d  = (total_new == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
                scnt_d   = accept ? stall_q : (scnt_q != 4'd0) ? scnt_q - 4'd1 : scnt_q;
                if (accept) begin
                    beats_d = beats_q + 32'd1;
                    err_d   = (mismatch && err_q != '1) ? err_q + 32'd1 : err_q;
                    first_d = (mismatch && first_q == '1) ? beats_q : first_q;
                    state_d = (beats_q == total_q - 32'd1) ? DONE : RUN;
                end
            end
            default: state_d = START_REG ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            total_q  <= '0;
            seed_q   <= '0;
            stall_q  <= '0;
            scnt_q   <= '0;
            beats_q  <= '0;
            cycles_q <= '0;
            err_q    <= '0;
            first_q  <= '1;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            seed_q   <= seed_d;
            stall_q  <= stall_d;
            scnt_q   <= scnt_d;
            beats_q  <= beats_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
            first_q  <= first_d;
        end
    end
endmodule

// File: tb/tb_axis_rd_checker.sv
// tb_axis_rd_checker: directed self-checking bench for axis_rd_checker
module tb_axis_rd_checker;
    logic        clk = 1'b0;
    logic        rstn;
    logic        s_axis_tvalid;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tstrb;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        START_REG;
    logic [31:0] NBURST_REG, SEED_REG;
    logic [3:0]  STALL_REG;
    logic        DONE_REG, BUSY_REG;
    logic [31:0] BEATS_REG, CYCLES_REG, ERR_CNT_REG, FIRST_ERR_IDX_REG;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          idx, rdy_cnt, bad1, bad2;
    logic        timeout, acc;
    axis_rd_checker #(.DATA_WIDTH(64), .BURST_LENGTH(7)) dut (
        .clk(clk), .rstn(rstn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .START_REG(START_REG), .NBURST_REG(NBURST_REG), .SEED_REG(SEED_REG),
        .STALL_REG(STALL_REG), .DONE_REG(DONE_REG), .BUSY_REG(BUSY_REG),
        .BEATS_REG(BEATS_REG), .CYCLES_REG(CYCLES_REG), .ERR_CNT_REG(ERR_CNT_REG),
        .FIRST_ERR_IDX_REG(FIRST_ERR_IDX_REG)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] beat(input int i);
        logic [31:0] w;
        logic [63:0] d;
        w = SEED_REG + 32'(i);
        d = {w, w};
        if (i == bad1) d[63:32] = 32'hDEADBEEF;
        if (i == bad2) d[0] = ~d[0];
        return d;
    endfunction
    // Called on a negedge; offers n_send beats and returns on the negedge DONE is seen.
    task automatic run(input logic [31:0] seed, input logic [31:0] nb, input logic [3:0] stall, input int n_send);
        SEED_REG = seed;
        NBURST_REG = nb;
        STALL_REG = stall;
        START_REG = 1'b1;
        idx = 0;
        rdy_cnt = 0;
        timeout = 1'b1;
        for (int c = 0; c < 400; c++) begin
            s_axis_tvalid = idx < n_send;
            s_axis_tdata = beat(idx);
            if (s_axis_tready) rdy_cnt++;
            acc = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            if (DONE_REG) begin
                timeout = 1'b0;
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        check("run_timeout", 32'(timeout), 32'd0);
    endtask
    task automatic stop_run(input string tag);
        START_REG = 1'b0;
        @(negedge clk);
        check(tag, 32'(DONE_REG), 32'd0);
    endtask
    initial begin
        rstn = 1'b0;
        START_REG = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tstrb = '1;
        s_axis_tlast = 1'b0;
        NBURST_REG = '0;
        SEED_REG = '0;
        STALL_REG = '0;
        bad1 = -1;
        bad2 = -1;
        repeat (2) @(negedge clk);
        check("rst_done", 32'(DONE_REG), 32'd0);
        check("rst_busy", 32'(BUSY_REG), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_beats", BEATS_REG, 32'd0);
        check("rst_cycles", CYCLES_REG, 32'd0);
        check("rst_err", ERR_CNT_REG, 32'd0);
        check("rst_first", FIRST_ERR_IDX_REG, 32'hFFFFFFFF);
        rstn = 1'b1;
        @(negedge clk);
        run(32'h100, 32'd2, 4'd0, 20);
        check("t1_beats", BEATS_REG, 32'd16);
        check("t1_err", ERR_CNT_REG, 32'd0);
        check("t1_first", FIRST_ERR_IDX_REG, 32'hFFFFFFFF);
        check("t1_cycles", CYCLES_REG, 32'd16);
        check("t1_busy", 32'(BUSY_REG), 32'd0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = beat(16);
        check("t1_done_tready", 32'(s_axis_tready), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_done_frozen", BEATS_REG, 32'd16);
        s_axis_tvalid = 1'b0;
        stop_run("t1_idle_done");
        bad1 = 5;
        bad2 = 9;
        run(32'h100, 32'd2, 4'd0, 16);
        check("t2_err", ERR_CNT_REG, 32'd2);
        check("t2_first", FIRST_ERR_IDX_REG, 32'd5);
        check("t2_beats", BEATS_REG, 32'd16);
        stop_run("t2_idle_done");
        bad1 = 7;
        bad2 = -1;
        run(32'h2000, 32'd1, 4'd0, 8);
        check("tlast_err", ERR_CNT_REG, 32'd1);
        check("tlast_first", FIRST_ERR_IDX_REG, 32'd7);
        stop_run("tlast_idle_done");
        bad1 = -1;
        run(32'h55, 32'd1, 4'd3, 8);
        check("t3_beats", BEATS_REG, 32'd8);
        check("t3_cycles", CYCLES_REG, 32'd29);
        check("t3_ready_cycles", 32'(rdy_cnt), 32'd8);
        check("t3_err", ERR_CNT_REG, 32'd0);
        stop_run("t3_idle_done");
        NBURST_REG = 32'd0;
        START_REG = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        check("t4_latch_done", 32'(DONE_REG), 32'd0);
        check("t4_latch_tready", 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        check("t4_done", 32'(DONE_REG), 32'd1);
        check("t4_tready", 32'(s_axis_tready), 32'd0);
        check("t4_beats", BEATS_REG, 32'd0);
        check("t4_cycles", CYCLES_REG, 32'd0);
        s_axis_tvalid = 1'b0;
        stop_run("t4_idle_done");
        run(32'hFFFFFFFE, 32'd1, 4'd0, 8);
        check("t5_err", ERR_CNT_REG, 32'd0);
        check("t5_first", FIRST_ERR_IDX_REG, 32'hFFFFFFFF);
        check("t5_beats", BEATS_REG, 32'd8);
        stop_run("t5_idle_done");
        SEED_REG = 32'h10;
        NBURST_REG = 32'd2;
        STALL_REG = 4'd0;
        START_REG = 1'b1;
        bad1 = 1;
        idx = 0;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = beat(idx);
            acc = s_axis_tready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
        end
        check("t6_pre_beats", BEATS_REG, 32'd4);
        s_axis_tvalid = 1'b0;
        START_REG = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("t6_rst_beats", BEATS_REG, 32'd0);
        check("t6_rst_cycles", CYCLES_REG, 32'd0);
        check("t6_rst_err", ERR_CNT_REG, 32'd0);
        check("t6_rst_first", FIRST_ERR_IDX_REG, 32'hFFFFFFFF);
        check("t6_rst_tready", 32'(s_axis_tready), 32'd0);
        check("t6_rst_busy", 32'(BUSY_REG), 32'd0);
        @(negedge clk);
        bad1 = -1;
        run(32'h10, 32'd2, 4'd0, 16);
        check("t6_beats", BEATS_REG, 32'd16);
        check("t6_err", ERR_CNT_REG, 32'd0);
        check("t6_cycles", CYCLES_REG, 32'd16);
        stop_run("t6_idle_done");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_rd_checker.md
Name: axis_rd_checker

Overview:
- Downstream sink for the DDR bandwidth-test read master. Consumes its AXI-Stream output (data read back from DDR) and checks every beat against an expected incrementing pattern.
- Measures elapsed cycles from run start to the final expected beat, giving software a read-bandwidth figure and a data-integrity result through plain register ports.
- Supports programmable back-pressure so the read path's FIFO-full behaviour can be exercised.

Parameters:
- DATA_WIDTH, 64, AXIS data width; must be a multiple of 32.
- BURST_LENGTH, 7, AXI burst length minus 1, matching the read master; beats per burst = BURST_LENGTH+1.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_axis_tvalid  in  1  stream data valid
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tstrb  in  DATA_WIDTH/8  ignored
- s_axis_tlast  in  1  ignored; the read master ties it to 0
- s_axis_tready  out  1  sink ready
- START_REG  in  1  run request, level; same protocol as the read master's START_REG
- NBURST_REG  in  32  number of bursts expected
- SEED_REG  in  32  pattern seed
- STALL_REG  in  4  tready-low cycles inserted after each accepted beat
- DONE_REG  out  1  run complete
- BUSY_REG  out  1  run in progress
- BEATS_REG  out  32  beats accepted this run
- CYCLES_REG  out  32  elapsed run cycles
- ERR_CNT_REG  out  32  mismatching beats
- FIRST_ERR_IDX_REG  out  32  beat index of first mismatch; 0xFFFFFFFF if none

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE. All outputs 0 except FIRST_ERR_IDX_REG=0xFFFFFFFF. Internal stall counter 0.
- Reset mid-run: abandons the run immediately. No partial result is kept.
- State machine:
  - IDLE: BUSY=0, DONE=0, tready=0. START_REG=1 -> LATCH.
  - LATCH (1 cycle):
    - Latch total = NBURST_REG*(BURST_LENGTH+1), 32-bit, upper product bits discarded. Also latch SEED_REG and STALL_REG.
    - Clear BEATS, CYCLES, ERR_CNT, stall counter; set FIRST_ERR_IDX=0xFFFFFFFF.
    - Next state: DONE if total==0, else RUN.
  - RUN: BUSY=1.
    - CYCLES increments every cycle in RUN, including the cycle of the final accept, saturating at 0xFFFFFFFF.
    - Next state: DONE on the cycle the beat with index total-1 is accepted.
  - DONE: BUSY=0, DONE=1, tready=0, results frozen. START_REG=0 -> IDLE.
  - START_REG falling while in RUN is ignored; the run completes normally.
- Handshake:
  - Beat accepted when s_axis_tvalid && s_axis_tready at the clk edge.
  - s_axis_tready = (state==RUN) && (stall counter==0). It is a registered decision; no combinational path from tvalid.
  - On accept, the stall counter loads the latched STALL value. While nonzero it decrements once per cycle.
  - STALL=0 gives full-rate acceptance: one beat per cycle when tvalid is held high.
  - tvalid without tready is legal and is not counted.
- Checking, for beat index i = BEATS value before the increment:
  - Expected word = (seed+i) mod 2^32, replicated into every 32-bit lane of DATA_WIDTH.
  - Mismatch when any bit differs: ERR_CNT increments, saturating at 0xFFFFFFFF. FIRST_ERR_IDX latches i only if still 0xFFFFFFFF.
  - BEATS increments on every accept.
  - Pattern wraps naturally: seed 0xFFFFFFFF, i=1 -> expected lane 0x00000000.
- Simultaneous events:
  - An accept on the final beat and a mismatch on that same beat are both recorded before DONE.
  - Beats offered in DONE or IDLE are not accepted; they stay in the upstream FIFO.
- Latency: results are valid in the first cycle DONE_REG=1. Register outputs are driven directly from flops.

Test Plan:
- SEED=0x100, NBURST=2, STALL=0; upstream sends 16 correct beats back-to-back with tvalid high -> BEATS=16, ERR_CNT=0, FIRST_ERR_IDX=0xFFFFFFFF, CYCLES=16, DONE=1. Then drop START -> IDLE, DONE=0.
- Same setup, but beat 5 data has lane 1 flipped to 0xDEADBEEF and beat 9 is also wrong -> ERR_CNT=2, FIRST_ERR_IDX=5, BEATS=16.
- STALL=3, NBURST=1, tvalid always high -> tready high 1 cycle in every 4. 8 beats accepted; CYCLES=29.
- NBURST=0, START pulsed -> DONE asserted 2 cycles after START is sampled. BEATS=0, CYCLES=0, tready never high.
- SEED=0xFFFFFFFE, NBURST=1, correct wrapping data (0xFFFFFFFE, 0xFFFFFFFF, 0x0, ...) -> ERR_CNT=0.
- rstn low for 1 cycle after 4 beats of a 16-beat run -> state IDLE, all counters 0, tready=0. A new START runs cleanly to BEATS=16.
